pipe_trace_buffer: RTL and testbench

- Synthesizable, parametrised hardware trace capture for any MIPS pipeline register (IF/ID first: PC+4 and instruction word).
- Records the per-cycle record {cycle number, address, instruction} into a circular buffer with pre-trigger history and a programmable post-trigger window, then freezes for readout.
- Sits beside the MIPS core, driven by the core clock.
- Replaces simulator-only monitoring, so traces also work on hardware.

---
 rtl/pipe_trace_buffer.sv | 100 ++++++++++
 tb/tb_pipe_trace_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer.sv
// Trace capture for a pipeline register: circular history of {cycle, addr, instr}
// with pre-trigger history and a post-trigger window, frozen for readout once done.
module pipe_trace_buffer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 32,
  parameter int POST_TRIG = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CAP_EN,
  input  logic              TRIG,
  input  logic              IN_VALID,
  input  logic [ADDR_W-1:0] IN_ADR,
  input  logic [DATA_W-1:0] IN_INS,
  input  logic              RD_EN,
  input  logic [AW-1:0]     RD_IDX,
  output logic [CNT_W-1:0]  RD_CYCLE,
  output logic [ADDR_W-1:0] RD_ADR,
  output logic [DATA_W-1:0] RD_INS,
  output logic              RD_VALID,
  output logic [1:0]        STATE,
  output logic [CNT_W-1:0]  CYCLE_COUNT,
  output logic [AW:0]       ENTRY_COUNT
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  localparam int          REC_W = CNT_W + ADDR_W + DATA_W;
  localparam logic [AW-1:0] PT_L  = AW'(POST_TRIG);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);

  state_t           state;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    pcnt;
  logic [REC_W-1:0] mem [DEPTH];

  logic          wr;
  logic          rd_ok;
  logic [AW-1:0] raddr;

  assign STATE = state;
  assign wr    = (state == ARMED || state == POST) && IN_VALID;
  // Index 0 is the oldest entry; when full this lands on wptr itself.
  assign raddr = wptr - ENTRY_COUNT[AW-1:0] + RD_IDX;
  assign rd_ok = RD_EN && (state == DONE) && ({1'b0, RD_IDX} < ENTRY_COUNT);

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge CLK) begin
    if (wr) mem[wptr] <= {CYCLE_COUNT, IN_ADR, IN_INS};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      CYCLE_COUNT <= '0;
      ENTRY_COUNT <= '0;
      wptr        <= '0;
      pcnt        <= '0;
      RD_VALID    <= 1'b0;
      RD_CYCLE    <= '0;
      RD_ADR      <= '0;
      RD_INS      <= '0;
    end else begin
      CYCLE_COUNT <= CYCLE_COUNT + CNT_W'(1);
      if (wr) begin
        wptr <= wptr + AW'(1);
        if (ENTRY_COUNT != FULL) ENTRY_COUNT <= ENTRY_COUNT + (AW+1)'(1);
      end
      case (state)
        IDLE: if (CAP_EN) begin
          state       <= ARMED;
          wptr        <= '0;
          ENTRY_COUNT <= '0;
        end
        ARMED: begin
          if (!CAP_EN) state <= IDLE;
          else if (TRIG) begin
            state <= (POST_TRIG == 0) ? DONE : POST;
            pcnt  <= PT_L;
          end
        end
        POST: begin
          if (!CAP_EN) state <= IDLE;
          else if (IN_VALID) begin
            pcnt <= pcnt - AW'(1);
            if (pcnt == AW'(1)) state <= DONE;
          end
        end
        DONE: if (!CAP_EN) state <= IDLE;
        default: state <= IDLE;
      endcase
      RD_VALID <= rd_ok;
      if (rd_ok) {RD_CYCLE, RD_ADR, RD_INS} <= mem[raddr];
    end
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench: one default instance plus a small one (DEPTH=4, CNT_W=4, POST_TRIG=0).
module tb_pipe_trace_buffer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1, CAP_EN = 1'b0, TRIG = 1'b0, IN_VALID = 1'b0, RD_EN = 1'b0;
  logic [31:0] IN_ADR = '0, IN_INS = '0;
  logic [3:0]  RD_IDX = '0;

  logic [31:0] m_rd_cycle, m_rd_adr, m_rd_ins, m_cyc;
  logic        m_rd_valid;
  logic [1:0]  m_state;
  logic [4:0]  m_ecnt;

  logic [3:0]  s_rd_cycle, s_cyc;
  logic [31:0] s_rd_adr, s_rd_ins;
  logic        s_rd_valid;
  logic [1:0]  s_state;
  logic [2:0]  s_ecnt;

  int n_chk = 0, n_err = 0;
  int tcyc  = 0;
  int stamp [64];

  always #5 CLK = ~CLK;

  pipe_trace_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .CNT_W(32), .POST_TRIG(8)) u_main (
    .CLK(CLK), .RST(RST), .CAP_EN(CAP_EN), .TRIG(TRIG), .IN_VALID(IN_VALID),
    .IN_ADR(IN_ADR), .IN_INS(IN_INS), .RD_EN(RD_EN), .RD_IDX(RD_IDX),
    .RD_CYCLE(m_rd_cycle), .RD_ADR(m_rd_adr), .RD_INS(m_rd_ins), .RD_VALID(m_rd_valid),
    .STATE(m_state), .CYCLE_COUNT(m_cyc), .ENTRY_COUNT(m_ecnt));

  pipe_trace_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .CNT_W(4), .POST_TRIG(0)) u_small (
    .CLK(CLK), .RST(RST), .CAP_EN(CAP_EN), .TRIG(TRIG), .IN_VALID(IN_VALID),
    .IN_ADR(IN_ADR), .IN_INS(IN_INS), .RD_EN(RD_EN), .RD_IDX(RD_IDX[1:0]),
    .RD_CYCLE(s_rd_cycle), .RD_ADR(s_rd_adr), .RD_INS(s_rd_ins), .RD_VALID(s_rd_valid),
    .STATE(s_state), .CYCLE_COUNT(s_cyc), .ENTRY_COUNT(s_ecnt));

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] adr;
    logic [31:0] ins;
    int          k;
  } rd_vec_t;

  typedef struct {
    logic [1:0]  idx;
    logic        vld;
    logic [31:0] adr;
    logic [3:0]  cyc;
  } srd_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (RST) tcyc = 0;
    else tcyc++;
  endtask

  rd_vec_t  tbl  [16];
  srd_vec_t stbl [4];
  logic [31:0] exp_adr [$];
  int          exp_stamp [$];
  logic [31:0] prev;

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '{idx: 4'(i), adr: 32'(52 + 4*i), ins: 32'hA000_0000 + 32'(13 + i), k: 13 + i};
    stbl[0] = '{2'd0, 1'b1, 32'h300, 4'd14};
    stbl[1] = '{2'd1, 1'b1, 32'h304, 4'd15};
    stbl[2] = '{2'd2, 1'b1, 32'h308, 4'd0};
    stbl[3] = '{2'd3, 1'b0, 32'h308, 4'd0};

    // Reset held two cycles, then the counter runs
    step(); step();
    chk("rst_state", m_state, 0);
    chk("rst_ecnt", m_ecnt, 0);
    chk("rst_cyc", m_cyc, 0);
    chk("rst_rdv", m_rd_valid, 0);
    chk("rst_rdadr", m_rd_adr, 0);
    RST = 1'b0;
    step(); chk("cyc_1", m_cyc, 1);
    step(); chk("cyc_2", m_cyc, 2);

    // 30 valid samples, trigger at k=20, 8 post samples
    CAP_EN = 1'b1;
    step();
    chk("armed", m_state, 1);
    chk("armed_ecnt", m_ecnt, 0);
    for (int k = 0; k < 30; k++) begin
      IN_VALID = 1'b1; IN_ADR = 32'(4*k); IN_INS = 32'hA000_0000 + 32'(k);
      TRIG = (k == 20);
      stamp[k] = tcyc;
      step();
      if (k == 20) chk("post_at_trig", m_state, 2);
      if (k == 27) chk("post_at_27", m_state, 2);
      if (k == 28) chk("done_at_28", m_state, 3);
    end
    TRIG = 1'b0; IN_VALID = 1'b0;
    chk("full_ecnt", m_ecnt, 16);
    for (int i = 0; i < 16; i++) begin
      RD_EN = 1'b1; RD_IDX = tbl[i].idx;
      step();
      chk("rd_valid", m_rd_valid, 1);
      chk("rd_adr", m_rd_adr, tbl[i].adr);
      chk("rd_ins", m_rd_ins, tbl[i].ins);
      chk("rd_cycle", m_rd_cycle, 64'(stamp[tbl[i].k]));
      if (i > 0) chk("rd_cycle_incr", 64'(m_rd_cycle > prev), 1);
      prev = m_rd_cycle;
    end
    RD_EN = 1'b0;
    step();
    chk("rden0_valid", m_rd_valid, 0);
    chk("rden0_hold", m_rd_adr, 112);
    chk("done_stays", m_state, 3);

    // Re-arm through IDLE; bubbles on every other cycle after the trigger
    CAP_EN = 1'b0;
    step();
    chk("done_idle", m_state, 0);
    chk("idle_ecnt_kept", m_ecnt, 16);
    CAP_EN = 1'b1;
    step();
    chk("rearm_ecnt", m_ecnt, 0);
    for (int k = 0; k < 20; k++) begin
      IN_VALID = 1'b1; IN_ADR = 32'h1000 + 32'(4*k); TRIG = (k == 19);
      exp_adr.push_back(IN_ADR); exp_stamp.push_back(tcyc);
      step();
    end
    TRIG = 1'b0;
    chk("bub_post", m_state, 2);
    for (int j = 1; j <= 16; j++) begin
      IN_VALID = (j % 2 == 0);
      IN_ADR   = IN_VALID ? 32'h2000 + 32'(4*j) : 32'hDEAD_0000;
      if (IN_VALID) begin exp_adr.push_back(IN_ADR); exp_stamp.push_back(tcyc); end
      step();
      if (j == 15) chk("bub_post_15", m_state, 2);
      if (j == 16) chk("bub_done_16", m_state, 3);
    end
    IN_VALID = 1'b0;
    while (exp_adr.size() > 16) begin void'(exp_adr.pop_front()); void'(exp_stamp.pop_front()); end
    for (int i = 0; i < 16; i++) begin
      RD_EN = 1'b1; RD_IDX = 4'(i);
      step();
      chk("bub_rd_adr", m_rd_adr, exp_adr[i]);
      chk("bub_rd_cyc", m_rd_cycle, 64'(exp_stamp[i]));
    end
    RD_EN = 1'b0;

    // Abort in POST, then abort-vs-trigger in ARMED
    CAP_EN = 1'b0; step();
    CAP_EN = 1'b1; step();
    IN_VALID = 1'b1; IN_ADR = 32'h4444; TRIG = 1'b1;
    step();
    chk("abort_pre_post", m_state, 2);
    TRIG = 1'b0; CAP_EN = 1'b0;
    step();
    chk("abort_idle", m_state, 0);
    IN_VALID = 1'b0; RD_EN = 1'b1; RD_IDX = 4'd0;
    step();
    chk("abort_rd_invalid", m_rd_valid, 0);
    RD_EN = 1'b0;
    CAP_EN = 1'b1; step();
    CAP_EN = 1'b0; TRIG = 1'b1;
    step();
    chk("abort_beats_trig", m_state, 0);
    TRIG = 1'b0;

    // Reset in the middle of ARMED
    CAP_EN = 1'b1; step();
    IN_VALID = 1'b1; step();
    IN_VALID = 1'b0; RD_EN = 1'b1; RST = 1'b1;
    step();
    chk("midrst_state", m_state, 0);
    chk("midrst_ecnt", m_ecnt, 0);
    chk("midrst_cyc", m_cyc, 0);
    chk("midrst_rdv", m_rd_valid, 0);
    chk("midrst_rdadr", m_rd_adr, 0);
    chk("midrst_rdins", m_rd_ins, 0);
    chk("midrst_rdcyc", m_rd_cycle, 0);
    RST = 1'b0; RD_EN = 1'b0; CAP_EN = 1'b0;

    // Small instance: 4-bit counter wrap, POST_TRIG=0
    while (tcyc < 13) step();
    chk("s_cyc_13", s_cyc, 13);
    CAP_EN = 1'b1;
    step();
    chk("s_armed", s_state, 1);
    for (int k = 0; k < 3; k++) begin
      IN_VALID = 1'b1; IN_ADR = 32'h300 + 32'(4*k); TRIG = (k == 2);
      step();
      if (k == 0) chk("s_cyc_15", s_cyc, 15);
      if (k == 1) begin chk("s_cyc_wrap", s_cyc, 0); chk("s_still_armed", s_state, 1); end
      if (k == 2) chk("s_done", s_state, 3);
    end
    IN_VALID = 1'b0; TRIG = 1'b0;
    chk("s_ecnt", s_ecnt, 3);
    for (int i = 0; i < 4; i++) begin
      RD_EN = 1'b1; RD_IDX = {2'b00, stbl[i].idx};
      step();
      chk("s_rd_valid", s_rd_valid, stbl[i].vld);
      chk("s_rd_adr", s_rd_adr, stbl[i].adr);
      chk("s_rd_cyc", s_rd_cycle, stbl[i].cyc);
    end
    RD_EN = 1'b0;
    while (tcyc < 21) step();
    chk("s_cyc_21", s_cyc, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
